// File: rtl/cpu6502_pkg.sv
// ---------------------------------------------------------------------------
// cpu6502_pkg
// Shared definitions for the 6502 front end (fetch queue and decoder).
//   ADDR_W / DATA_W    : address and data bus widths
//   inst_len_t         : instruction length in bytes, legal values 1..3
//   RESET_PC_DEFAULT   : default fetch PC after reset
//   fetch_state_t      : fetch FSM states
// ---------------------------------------------------------------------------
package cpu6502_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef logic [1:0] inst_len_t;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_REQ
    } fetch_state_t;

endpackage

// File: rtl/opcode_len.sv
// ---------------------------------------------------------------------------
// opcode_len
// Combinational 6502 instruction length lookup, shared by the fetch queue
// and the decoder.
//   opcode : in  8  opcode byte (aaabbbcc)
//   len    : out 2  instruction length in bytes, 1..3
// ---------------------------------------------------------------------------
module opcode_len
    import cpu6502_pkg::*;
(
    input  logic [DATA_W-1:0] opcode,
    output inst_len_t         len
);

    logic [2:0] bbb;
    logic [1:0] cc;

    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    // BRK/RTI/RTS are single-byte even though their bbb field suggests
    // otherwise, and JSR abs is three bytes; everything else follows the
    // addressing-mode field.
    always_comb begin
        len = 2'd1;
        if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
            len = 2'd1;
        end else if (opcode == 8'h20) begin
            len = 2'd3;
        end else begin
            case (cc)
                2'b01: begin
                    if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
                        len = 2'd3;
                    else
                        len = 2'd2;
                end
                2'b00, 2'b10: begin
                    case (bbb)
                        3'b000, 3'b001, 3'b100, 3'b101: len = 2'd2;
                        3'b010, 3'b110:                 len = 2'd1;
                        default:                        len = 2'd3;
                    endcase
                end
                default: len = 2'd1;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
// 6502 instruction fetch stage. Prefetches bytes from a byte-wide memory
// port into a circular queue and presents one whole instruction per
// valid/ready handshake. Redirects flush the queue and restart fetch.
//   clk, rst_n        : clock, asynchronous active-low reset
//   mem_req/mem_addr  : byte read request, held until mem_ack
//   mem_ack/mem_rdata : request accepted, read byte valid same cycle
//   inst_valid/ready  : instruction handshake to the decoder
//   inst_opcode/op_lo/op_hi/len/pc : instruction fields
//   redirect_valid/pc : flush and restart fetch at redirect_pc
// ---------------------------------------------------------------------------
module inst_fetch_queue
    import cpu6502_pkg::*;
#(
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_opcode,
    output logic [DATA_W-1:0] inst_op_lo,
    output logic [DATA_W-1:0] inst_op_hi,
    output inst_len_t         inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    logic [DATA_W-1:0] queue [QDEPTH];
    logic [PTR_W-1:0]  head, tail, head_p1, head_p2;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] fetch_pc, head_pc, held_addr;
    logic              discard;
    logic              ack_seen, push, fire;
    fetch_state_t      state, state_next;

    opcode_len u_opcode_len (
        .opcode (inst_opcode),
        .len    (inst_len)
    );

    // While a discarded request is still outstanding the address must stay
    // on the one that was issued, even though fetch_pc already points at the
    // redirect target.
    assign mem_req  = (state == FETCH_REQ);
    assign mem_addr = discard ? held_addr : fetch_pc;

    assign head_p1     = head + PTR_W'(1);
    assign head_p2     = head + PTR_W'(2);
    assign inst_opcode = queue[head];
    assign inst_op_lo  = (inst_len >= 2'd2) ? queue[head_p1] : '0;
    assign inst_op_hi  = (inst_len == 2'd3) ? queue[head_p2] : '0;
    assign inst_pc     = head_pc;
    assign inst_valid  = (count >= CNT_W'(inst_len));

    // A redirect blocks both the push and the pop of its cycle.
    assign ack_seen = mem_req & mem_ack;
    assign push     = ack_seen & ~discard & ~redirect_valid;
    assign fire     = inst_valid & inst_ready & ~redirect_valid;

    always_comb begin
        count_next = count;
        if (redirect_valid)
            count_next = '0;
        else
            count_next = count + CNT_W'(push) - (fire ? CNT_W'(inst_len) : '0);
    end

    // Fetch FSM: keep one request outstanding as long as the queue will
    // still have room for the byte it returns.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: begin
                if (count < FULL)
                    state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (ack_seen && count_next >= FULL)
                    state_next = FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            fetch_pc  <= RESET_PC;
            head_pc   <= RESET_PC;
            held_addr <= RESET_PC;
            discard   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++)
                queue[i] <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_valid) begin
                head     <= tail;
                fetch_pc <= redirect_pc;
                head_pc  <= redirect_pc;
                // An unacknowledged request cannot be withdrawn; remember
                // to drop its byte. An ack in this cycle retires it here.
                if (mem_req && !mem_ack) begin
                    discard   <= 1'b1;
                    held_addr <= mem_addr;
                end else begin
                    discard <= 1'b0;
                end
            end else begin
                if (ack_seen) begin
                    if (discard)
                        discard <= 1'b0;
                    else
                        fetch_pc <= fetch_pc + 16'd1;
                end
                if (push) begin
                    queue[tail] <= mem_rdata;
                    tail        <= tail + PTR_W'(1);
                end
                if (fire) begin
                    head    <= head + PTR_W'(inst_len);
                    head_pc <= head_pc + ADDR_W'(inst_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed self-checking bench for inst_fetch_queue with a byte memory
// model that acknowledges combinationally whenever ack_en is set.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [7:0]  inst_op_lo;
    logic [7:0]  inst_op_hi;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        ack_en;
    logic [7:0]  mem_model [0:65535];

    int checks   = 0;
    int failures = 0;
    int occ      = 0;
    int occ_bad  = 0;

    inst_fetch_queue #(.QDEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_opcode    (inst_opcode),
        .inst_op_lo     (inst_op_lo),
        .inst_op_hi     (inst_op_hi),
        .inst_len       (inst_len),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Memory model answers in the same cycle as the request
    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem_model[mem_addr];

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hold reset across two edges with quiet inputs, release at a falling edge
    task automatic applyReset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        ack_en         = 1'b1;
        occ            = 0;
        occ_bad        = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Shadow occupancy from observed acks and pops, called once per falling edge
    task automatic trackOccupancy();
        if (occ > 4) occ_bad++;
        if (occ == 4 && mem_req) occ_bad++;
        if (mem_req && mem_ack) occ++;
        if (inst_valid && inst_ready && !redirect_valid) occ -= int'(inst_len);
    endtask

    // Bounded wait for inst_valid at a falling edge
    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        logic [7:0]  rec_op  [2];
        logic [7:0]  rec_lo  [2];
        logic [7:0]  rec_hi  [2];
        logic [1:0]  rec_len [2];
        logic [15:0] rec_pc  [2];
        logic [15:0] ack_addr [3];
        int nrec, nack, acks, unstable, n;

        for (int a = 0; a < 65536; a++) mem_model[a] = 8'hEA;

        // ---- Reset values and first instruction latency (A9 05) ----
        mem_model[0] = 8'hA9; mem_model[1] = 8'h05;
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; ack_en = 1'b1;
        #1;
        checkOutput("rst_mem_req",    {31'd0, mem_req},    32'd0);
        checkOutput("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("rst_mem_addr",   {16'd0, mem_addr},   32'h0000);
        checkOutput("rst_opcode",     {24'd0, inst_opcode}, 32'h00);
        checkOutput("rst_len",        {30'd0, inst_len},   32'd1);
        applyReset();
        #1;
        checkOutput("A_req_before_edge", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        checkOutput("A_req_first_edge", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        checkOutput("A_valid_one_byte", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("A_valid_two_bytes", {31'd0, inst_valid}, 32'd1);
        checkOutput("A_opcode", {24'd0, inst_opcode}, 32'hA9);
        checkOutput("A_op_lo",  {24'd0, inst_op_lo},  32'h05);
        checkOutput("A_op_hi",  {24'd0, inst_op_hi},  32'h00);
        checkOutput("A_len",    {30'd0, inst_len},    32'd2);
        checkOutput("A_pc",     {16'd0, inst_pc},     32'h0000);

        // ---- AD 34 12 EA with decoder always ready ----
        mem_model[0] = 8'hAD; mem_model[1] = 8'h34;
        mem_model[2] = 8'h12; mem_model[3] = 8'hEA;
        applyReset();
        inst_ready = 1'b1;
        nrec = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (inst_valid && nrec < 2) begin
                rec_op[nrec]  = inst_opcode;
                rec_lo[nrec]  = inst_op_lo;
                rec_hi[nrec]  = inst_op_hi;
                rec_len[nrec] = inst_len;
                rec_pc[nrec]  = inst_pc;
                nrec++;
            end
            trackOccupancy();
        end
        checkOutput("B_fired_count", nrec, 2);
        if (nrec == 2) begin
            checkOutput("B0_opcode", {24'd0, rec_op[0]},  32'hAD);
            checkOutput("B0_op_lo",  {24'd0, rec_lo[0]},  32'h34);
            checkOutput("B0_op_hi",  {24'd0, rec_hi[0]},  32'h12);
            checkOutput("B0_len",    {30'd0, rec_len[0]}, 32'd3);
            checkOutput("B0_pc",     {16'd0, rec_pc[0]},  32'h0000);
            checkOutput("B1_opcode", {24'd0, rec_op[1]},  32'hEA);
            checkOutput("B1_op_lo",  {24'd0, rec_lo[1]},  32'h00);
            checkOutput("B1_len",    {30'd0, rec_len[1]}, 32'd1);
            checkOutput("B1_pc",     {16'd0, rec_pc[1]},  32'h0003);
        end
        checkOutput("B_occupancy", occ_bad, 0);

        // ---- Decoder stalled: queue fills to 4 and requests stop ----
        mem_model[0] = 8'hEA; mem_model[1] = 8'hEA;
        mem_model[2] = 8'hEA;
        applyReset();
        acks = 0; unstable = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
            if (inst_valid && (inst_opcode !== 8'hEA || inst_pc !== 16'h0000 || inst_len !== 2'd1))
                unstable++;
            trackOccupancy();
        end
        checkOutput("C_ack_count", acks, 4);
        checkOutput("C_req_when_full", {31'd0, mem_req}, 32'd0);
        checkOutput("C_outputs_stable", unstable, 0);
        checkOutput("C_occupancy", occ_bad, 0);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n = 0;
        while (!mem_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        checkOutput("C_req_after_pop", {31'd0, mem_req}, 32'd1);
        checkOutput("C_addr_after_pop", {16'd0, mem_addr}, 32'h0004);
        checkOutput("C_pc_after_pop", {16'd0, inst_pc}, 32'h0001);

        // ---- Redirect while a request to 0002 is pending ----
        mem_model[2] = 8'h4C; mem_model[16'h8000] = 8'hEA;
        applyReset();
        n = 0;
        while (!(mem_req && mem_addr == 16'h0002) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("D_reach_0002", {16'd0, mem_addr}, 32'h0002);
        ack_en = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h8000;
        @(negedge clk);
        redirect_valid = 1'b0;
        checkOutput("D_valid_after_redirect", {31'd0, inst_valid}, 32'd0);
        checkOutput("D_req_held", {31'd0, mem_req}, 32'd1);
        checkOutput("D_addr_held", {16'd0, mem_addr}, 32'h0002);
        ack_en = 1'b1;
        @(negedge clk);
        checkOutput("D_addr_resume", {16'd0, mem_addr}, 32'h8000);
        checkOutput("D_valid_discarded", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        checkOutput("D_valid_new", {31'd0, inst_valid}, 32'd1);
        checkOutput("D_opcode", {24'd0, inst_opcode}, 32'hEA);
        checkOutput("D_pc", {16'd0, inst_pc}, 32'h8000);
        mem_model[2] = 8'hEA;

        // ---- Redirect coincident with fire and mem_ack ----
        mem_model[16'h1000] = 8'hEA;
        applyReset();
        inst_ready = 1'b1;
        @(negedge clk);
        waitValid("E_wait_valid");
        checkOutput("E_ack_coincident", {31'd0, mem_ack}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h1000;
        @(negedge clk);
        redirect_valid = 1'b0; inst_ready = 1'b0;
        checkOutput("E_valid_after_redirect", {31'd0, inst_valid}, 32'd0);
        checkOutput("E_addr", {16'd0, mem_addr}, 32'h1000);
        @(negedge clk);
        checkOutput("E_valid_new", {31'd0, inst_valid}, 32'd1);
        checkOutput("E_pc", {16'd0, inst_pc}, 32'h1000);

        // ---- Fetch across FFFF -> 0000 with JMP abs ----
        mem_model[16'hFFFF] = 8'h4C; mem_model[0] = 8'h34; mem_model[1] = 8'h12;
        applyReset();
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req && mem_ack && nack < 3) begin
                ack_addr[nack] = mem_addr;
                nack++;
            end
            @(negedge clk);
        end
        checkOutput("F_ack_count", nack, 3);
        if (nack == 3) begin
            checkOutput("F_addr0", {16'd0, ack_addr[0]}, 32'hFFFF);
            checkOutput("F_addr1", {16'd0, ack_addr[1]}, 32'h0000);
            checkOutput("F_addr2", {16'd0, ack_addr[2]}, 32'h0001);
        end
        checkOutput("F_valid",  {31'd0, inst_valid}, 32'd1);
        checkOutput("F_opcode", {24'd0, inst_opcode}, 32'h4C);
        checkOutput("F_op_lo",  {24'd0, inst_op_lo},  32'h34);
        checkOutput("F_op_hi",  {24'd0, inst_op_hi},  32'h12);
        checkOutput("F_len",    {30'd0, inst_len},    32'd3);
        checkOutput("F_pc",     {16'd0, inst_pc},     32'hFFFF);
        mem_model[16'hFFFF] = 8'hEA; mem_model[0] = 8'hEA; mem_model[1] = 8'hEA;

        // ---- Asynchronous reset in the middle of a pending request ----
        applyReset();
        @(negedge clk);
        waitValid("G_wait_valid");
        ack_en = 1'b0;
        @(negedge clk);
        checkOutput("G_req_pending", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("G_rst_mem_req",    {31'd0, mem_req},    32'd0);
        checkOutput("G_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("G_rst_mem_addr",   {16'd0, mem_addr},   32'h0000);
        checkOutput("G_rst_len",        {30'd0, inst_len},   32'd1);
        ack_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("G_restart_req",  {31'd0, mem_req},  32'd1);
        checkOutput("G_restart_addr", {16'd0, mem_addr}, 32'h0000);
        @(posedge clk); #1;
        checkOutput("G_restart_valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("G_restart_pc", {16'd0, inst_pc}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
